// File: rtl/spart_host_driver_if.sv
// Control/handshake signals between the SPART host driver and the SPART UART.
// The tristate data bus is a separate inout port on the driver.
interface spart_host_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr
    );
endinterface

// File: rtl/spart_host_driver.sv
// Host-side driver for the SPART UART: programs the baud divisor, then echoes received
// bytes through a small FIFO (or streams a fixed pattern byte when echo is disabled).
module spart_host_driver #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          ECHO_EN    = 1'b1,
    parameter logic [7:0]  PATTERN    = 8'h55,
    parameter logic [15:0] DIV0       = 16'h0516,
    parameter logic [15:0] DIV1       = 16'h028B,
    parameter logic [15:0] DIV2       = 16'h0146,
    parameter logic [15:0] DIV3       = 16'h00A3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg_i,
    spart_host_driver_if.master           bus,
    inout  wire  [7:0]                    databus_io,
    output logic                          cfg_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StInit,
        StDivl,
        StDivh,
        StIdle,
        StRead,
        StWrite
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        br_cfg_q, br_cfg_d;
    logic              cfg_done_q, cfg_done_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [15:0]       divisor;
    logic [7:0]        tx_byte;
    logic              drive_en;
    logic [7:0]        drive_data;

    assign fifo_full  = (cnt_q == CntW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        divisor = DIV0;
        unique case (br_cfg_q)
            2'd0: divisor = DIV0;
            2'd1: divisor = DIV1;
            2'd2: divisor = DIV2;
            2'd3: divisor = DIV3;
            default: divisor = DIV0;
        endcase
    end

    assign tx_byte = ECHO_EN ? fifo_mem_q[rd_ptr_q] : PATTERN;

    // Next-state logic; READ and WRITE always return to IDLE so the SPART gets a cycle
    // to update rda/tbr before the next access.
    always_comb begin
        state_d    = state_q;
        br_cfg_d   = br_cfg_q;
        cfg_done_d = cfg_done_q;
        push       = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            StInit: begin
                br_cfg_d = br_cfg_i;
                state_d  = StDivl;
            end
            StDivl: state_d = StDivh;
            StDivh: begin
                cfg_done_d = 1'b1;
                state_d    = StIdle;
            end
            StIdle: begin
                if (br_cfg_i != br_cfg_q) begin
                    cfg_done_d = 1'b0;
                    br_cfg_d   = br_cfg_i;
                    state_d    = StDivl;
                end else if (bus.rda && (!ECHO_EN || !fifo_full)) begin
                    state_d = StRead;
                end else if (bus.tbr && (!ECHO_EN || !fifo_empty)) begin
                    state_d = StWrite;
                end
            end
            StRead: begin
                push    = ECHO_EN;
                state_d = StIdle;
            end
            StWrite: begin
                pop     = ECHO_EN;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    // Bus outputs depend only on the state register and registered data.
    always_comb begin
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b00;
        drive_en   = 1'b0;
        drive_data = 8'h00;
        unique case (state_q)
            StDivl: begin
                bus.iocs   = 1'b1;
                bus.iorw   = 1'b0;
                bus.ioaddr = 2'b10;
                drive_en   = 1'b1;
                drive_data = divisor[7:0];
            end
            StDivh: begin
                bus.iocs   = 1'b1;
                bus.iorw   = 1'b0;
                bus.ioaddr = 2'b11;
                drive_en   = 1'b1;
                drive_data = divisor[15:8];
            end
            StRead: begin
                bus.iocs = 1'b1;
            end
            StWrite: begin
                bus.iocs   = 1'b1;
                bus.iorw   = 1'b0;
                drive_en   = 1'b1;
                drive_data = tx_byte;
            end
            default: begin
                bus.iocs = 1'b0;
            end
        endcase
    end

    assign databus_io = drive_en ? drive_data : 8'hzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            br_cfg_q   <= br_cfg_i;
            cfg_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            br_cfg_q   <= br_cfg_d;
            cfg_done_q <= cfg_done_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
                cnt_q    <= cnt_q + CntW'(1);
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                cnt_q    <= cnt_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem_q[wr_ptr_q] <= databus_io;
        end
    end

    assign cfg_done_o = cfg_done_q;
    assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_spart_host_driver.sv
// Randomised scoreboard bench: an echo-mode and a pattern-mode driver against simple
// SPART models; a negedge monitor compares every bus access with queued expectations.
module tb_spart_host_driver;

    localparam int Depth = 4;
    localparam logic [7:0] Keeper = 8'hE1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [15:0] div_of(input logic [1:0] c);
        case (c)
            2'd0: return 16'h0516;
            2'd1: return 16'h028B;
            2'd2: return 16'h0146;
            default: return 16'h00A3;
        endcase
    endfunction

    // Echo-mode DUT and its SPART model
    spart_host_driver_if bus_e ();
    wire  [7:0] databus;
    logic       cfg_done;
    logic [2:0] fifo_cnt;

    spart_host_driver dut_e (
        .clk        (clk),
        .rst        (rst),
        .br_cfg_i   (br_cfg),
        .bus        (bus_e),
        .databus_io (databus),
        .cfg_done_o (cfg_done),
        .fifo_cnt_o (fifo_cnt)
    );

    logic [7:0] rx_mem [64];
    logic [5:0] rx_wr = '0;
    logic [5:0] rx_rd = '0;
    logic [7:0] rx_head;
    assign rx_head   = rx_mem[rx_rd];
    assign bus_e.rda = (rx_wr != rx_rd);
    assign databus   = (bus_e.iocs && !bus_e.iorw) ? 8'hzz : (bus_e.iocs ? rx_head : Keeper);

    always @(posedge clk) begin
        if (!rst && bus_e.iocs && bus_e.iorw && bus_e.ioaddr == 2'b00 && bus_e.rda)
            rx_rd <= rx_rd + 6'd1;
    end

    // Pattern-mode DUT and its SPART model
    spart_host_driver_if bus_p ();
    wire  [7:0] databus_p;
    logic       cfg_done_p;
    logic [2:0] fifo_cnt_p;

    spart_host_driver #(
        .ECHO_EN (1'b0)
    ) dut_p (
        .clk        (clk),
        .rst        (rst),
        .br_cfg_i   (br_cfg),
        .bus        (bus_p),
        .databus_io (databus_p),
        .cfg_done_o (cfg_done_p),
        .fifo_cnt_o (fifo_cnt_p)
    );

    logic [3:0] p_rx_wr = '0;
    logic [3:0] p_rx_rd = '0;
    assign bus_p.rda = (p_rx_wr != p_rx_rd);
    assign bus_p.tbr = 1'b1;
    assign databus_p = (bus_p.iocs && !bus_p.iorw) ? 8'hzz : (bus_p.iocs ? 8'h3C : Keeper);

    always @(posedge clk) begin
        if (!rst && bus_p.iocs && bus_p.iorw && bus_p.ioaddr == 2'b00 && bus_p.rda)
            p_rx_rd <= p_rx_rd + 4'd1;
    end

    // Scoreboard: expected echo bytes and expected divisor writes {addr, data}
    logic [7:0] data_q [$];
    logic [9:0] div_q  [$];
    int         model_cnt = 0;
    logic       prev_data = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            data_q.delete();
            div_q.delete();
            model_cnt = 0;
            prev_data = 1'b0;
        end else begin
            chk("fifo_cnt", int'(fifo_cnt), model_cnt);
            if (bus_e.iocs && bus_e.ioaddr == 2'b00) begin
                chk("access_spacing", int'(prev_data), 0);
                if (bus_e.iorw) begin
                    chk("read_with_room", int'(model_cnt < Depth), 1);
                    model_cnt++;
                end else begin
                    chk("write_with_data", int'(model_cnt > 0), 1);
                    if (data_q.size() == 0) chk("echo_unexpected", int'(databus), -1);
                    else chk("echo_byte", int'(databus), int'(data_q.pop_front()));
                    if (model_cnt > 0) model_cnt--;
                end
            end else if (bus_e.iocs) begin
                chk("div_iorw", int'(bus_e.iorw), 0);
                if (div_q.size() == 0) chk("div_unexpected", int'({bus_e.ioaddr, databus}), -1);
                else chk("div_write", int'({bus_e.ioaddr, databus}), int'(div_q.pop_front()));
            end
            prev_data = bus_e.iocs && bus_e.ioaddr == 2'b00;
        end
    end

    int p_reads = 0;
    int p_writes = 0;
    always @(negedge clk) begin
        if (!rst && bus_p.iocs && bus_p.ioaddr == 2'b00) begin
            if (bus_p.iorw) p_reads++;
            else begin
                p_writes++;
                chk("pattern_byte", int'(databus_p), 8'h55);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 6'd1;
        data_q.push_back(b);
    endtask

    task automatic push_div(input logic [1:0] c);
        logic [15:0] d;
        d = div_of(c);
        div_q.push_back({2'b10, d[7:0]});
        div_q.push_back({2'b11, d[15:8]});
    endtask

    function automatic logic is_acc(input logic rd);
        return bus_e.iocs && bus_e.ioaddr == 2'b00 && bus_e.iorw == rd;
    endfunction

    task automatic wait_access(input logic rd, input int budget, output int cyc);
        cyc = 0;
        while (!is_acc(rd) && cyc < budget) begin
            step();
            cyc++;
        end
        if (!is_acc(rd)) chk("wait_access_timeout", 0, 1);
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((data_q.size() != 0 || div_q.size() != 0 || rx_wr != rx_rd || bus_e.iocs)
               && n < budget) begin
            step();
            n++;
        end
        if (data_q.size() != 0 || div_q.size() != 0 || rx_wr != rx_rd)
            chk("quiet_timeout", 0, 1);
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int p_base;
        rst       = 1'b1;
        br_cfg    = 2'b01;
        bus_e.tbr = 1'b0;
        repeat (3) step();

        chk("rst_iocs", int'(bus_e.iocs), 0);
        chk("rst_iorw", int'(bus_e.iorw), 1);
        chk("rst_ioaddr", int'(bus_e.ioaddr), 0);
        chk("rst_cfg_done", int'(cfg_done), 0);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_bus_released", int'(databus), int'(Keeper));

        rst = 1'b0;
        push_div(2'b01);
        chk("init_iocs", int'(bus_e.iocs), 0);
        step();
        chk("divl_iocs", int'(bus_e.iocs), 1);
        chk("divl_addr", int'(bus_e.ioaddr), 2);
        chk("divl_data", int'(databus), 8'h8B);
        step();
        chk("divh_addr", int'(bus_e.ioaddr), 3);
        chk("divh_data", int'(databus), 8'h02);
        step();
        chk("cfg_done_set", int'(cfg_done), 1);
        chk("idle_iocs", int'(bus_e.iocs), 0);
        chk("p_cfg_done", int'(cfg_done_p), 1);

        // Single echo with the transmitter ready
        bus_e.tbr = 1'b1;
        offer(8'hA7);
        wait_access(1'b1, 10, c);
        step();
        chk("cnt_after_read", int'(fifo_cnt), 1);
        wait_access(1'b0, 10, c);
        chk("read_to_write_gap", c, 1);
        chk("echo_a7", int'(databus), 8'hA7);
        step();
        chk("cnt_after_write", int'(fifo_cnt), 0);
        wait_quiet(50);

        // Five bytes into a four-deep FIFO while the transmitter is busy
        bus_e.tbr = 1'b0;
        for (int i = 0; i < 5; i++) offer(8'($urandom));
        repeat (20) step();
        chk("fifo_full_cnt", int'(fifo_cnt), Depth);
        chk("fifth_pending", int'(rx_wr - rx_rd), 1);
        chk("rda_held", int'(bus_e.rda), 1);
        bus_e.tbr = 1'b1;
        wait_quiet(100);
        chk("drained_cnt", int'(fifo_cnt), 0);

        // Divisor reprogramming, with a queued byte surviving it
        br_cfg = 2'b00;
        push_div(2'b00);
        wait_quiet(50);
        chk("cfg0_done", int'(cfg_done), 1);
        bus_e.tbr = 1'b0;
        offer(8'($urandom));
        repeat (6) step();
        chk("queued_cnt", int'(fifo_cnt), 1);
        br_cfg = 2'b11;
        push_div(2'b11);
        step();
        chk("cfg3_cleared", int'(cfg_done), 0);
        chk("cfg3_divl_addr", int'(bus_e.ioaddr), 2);
        chk("cfg3_divl_data", int'(databus), 8'hA3);
        step();
        chk("cfg3_divh_addr", int'(bus_e.ioaddr), 3);
        chk("cfg3_divh_data", int'(databus), 8'h00);
        step();
        chk("cfg3_done", int'(cfg_done), 1);
        chk("queued_kept", int'(fifo_cnt), 1);
        bus_e.tbr = 1'b1;
        wait_quiet(50);
        chk("queued_echoed_cnt", int'(fifo_cnt), 0);

        // Random traffic with a flickering transmitter
        for (int i = 0; i < 300; i++) begin
            bus_e.tbr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0 && 6'(rx_wr - rx_rd) < 6'd40) offer(8'($urandom));
            step();
        end
        bus_e.tbr = 1'b1;
        wait_quiet(400);
        chk("random_drained_cnt", int'(fifo_cnt), 0);

        // Pattern mode: the read clears rda, the byte is dropped, writes carry the pattern
        p_base = p_reads;
        p_rx_wr = p_rx_wr + 4'd1;
        repeat (8) step();
        chk("p_read_issued", p_reads - p_base, 1);
        chk("p_rda_cleared", int'(bus_p.rda), 0);
        chk("p_fifo_cnt", int'(fifo_cnt_p), 0);
        chk("p_writes_seen", int'(p_writes > 10), 1);

        // Reset in the middle of a WRITE
        bus_e.tbr = 1'b1;
        offer(8'($urandom));
        wait_access(1'b0, 20, c);
        rst = 1'b1;
        step();
        chk("rstw_iocs", int'(bus_e.iocs), 0);
        chk("rstw_bus_released", int'(databus), int'(Keeper));
        chk("rstw_fifo_cnt", int'(fifo_cnt), 0);
        chk("rstw_cfg_done", int'(cfg_done), 0);
        rst = 1'b0;
        push_div(br_cfg);
        chk("rstw_init_iocs", int'(bus_e.iocs), 0);
        step();
        chk("rstw_divl_addr", int'(bus_e.ioaddr), 2);
        chk("rstw_divl_data", int'(databus), 8'hA3);
        wait_quiet(50);
        chk("rstw_cfg_done_again", int'(cfg_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spart_host_driver.md
# spart_host_driver

Parametrised host-side driver for the SPART UART. It programs the 16-bit baud divisor from `br_cfg`, then services the receive and transmit buffers over the shared `iocs/iorw/ioaddr/databus` bus. In echo mode it retransmits every received byte through an internal FIFO; in pattern mode it transmits a fixed byte whenever the transmitter is ready. It also reprograms the divisor whenever `br_cfg` changes, without a reset.

## Interface
- `FIFO_DEPTH`, default 4: echo FIFO depth; power of two, ≥2.
- `ECHO_EN`, default 1: 1 = echo received bytes; 0 = transmit `PATTERN`.
- `PATTERN`, default 8'h55: byte sent when `ECHO_EN`=0.
- `DIV0`/`DIV1`/`DIV2`/`DIV3`, defaults 16'h0516 / 16'h028B / 16'h0146 / 16'h00A3: divisor for `br_cfg` 0/1/2/3.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `br_cfg` in 2: baud select.
- `rda` in 1: SPART receive data available.
- `tbr` in 1: SPART transmit buffer ready.
- `iocs` out 1: bus chip select.
- `iorw` out 1: 1 = read, 0 = write.
- `ioaddr` out 2: 00 = data, 10 = divisor low, 11 = divisor high.
- `databus` inout 8: driven only when `iocs`=1 and `iorw`=0, else high-Z.
- `cfg_done` out 1: divisor programmed for the current `br_cfg_q`.
- `fifo_cnt` out $clog2(FIFO_DEPTH)+1: echo FIFO occupancy.

## Operation
- FSM states: INIT, DIVL, DIVH, IDLE, READ, WRITE. All bus outputs are decoded from the state register and registered data (Moore).
- Per-state bus outputs:
  - INIT/IDLE: `iocs`=0, `iorw`=1, `ioaddr`=00.
  - DIVL: `iocs`=1, `iorw`=0, `ioaddr`=10, drives divisor[7:0].
  - DIVH: `iocs`=1, `iorw`=0, `ioaddr`=11, drives divisor[15:8].
  - READ: `iocs`=1, `iorw`=1, `ioaddr`=00.
  - WRITE: `iocs`=1, `iorw`=0, `ioaddr`=00, drives the tx byte.
- Transitions:
  - INIT→DIVL unconditionally. Latch `br_cfg_q`←`br_cfg`.
  - DIVL→DIVH→IDLE. `cfg_done`←1 on entry to IDLE from DIVH.
  - READ→IDLE and WRITE→IDLE always. This forces at least one idle cycle between accesses so the SPART can update `rda`/`tbr`.
- IDLE decisions, in priority order:
  1. If `br_cfg`≠`br_cfg_q`: `cfg_done`←0, latch `br_cfg_q`, go to DIVL.
  2. Else if `rda`=1 and (`ECHO_EN`=0 or FIFO not full): go to READ.
  3. Else if `tbr`=1 and (`ECHO_EN`=0 or FIFO not empty): go to WRITE.
  4. Else stay in IDLE.
- READ: `databus` is sampled at the posedge ending the READ cycle.
  - `ECHO_EN`=1: the byte is pushed into the FIFO.
  - `ECHO_EN`=0: the byte is discarded; the read is still issued to clear `rda`.
- WRITE:
  - `ECHO_EN`=1: drives the FIFO head; the pop occurs at the posedge ending WRITE.
  - `ECHO_EN`=0: drives `PATTERN`.
- FIFO full with `rda`=1: no read is issued. `rda` stays pending and no byte is lost or overwritten.
- FIFO empty with `tbr`=1 (echo mode): no write.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Push and pop never occur in the same cycle, because READ and WRITE are exclusive states.
- A `br_cfg` change during READ/WRITE completes that access first, then the divisor is reprogrammed from IDLE. FIFO contents are retained across reprogramming.
- Divisor byte order is fixed: low byte first, then high byte.

## Timing
- While `rst`=1 at a posedge: state←INIT, FIFO emptied, `fifo_cnt`=0, `cfg_done`=0, `br_cfg_q`←`br_cfg`. Outputs are then `iocs`=0, `iorw`=1, `ioaddr`=00, `databus` high-Z.
- Reset asserted mid-access aborts the access at that posedge. Any FIFO contents are lost.
- First cycle after `rst` falls: INIT. Next cycle: DIVL (`iocs`=1). Then DIVH. Then IDLE with `cfg_done`=1.
- Echo latency: `rda` seen in IDLE → READ next cycle → IDLE → WRITE at the earliest 2 cycles after READ (if `tbr`=1). That is 3 cycles minimum from the IDLE that sees `rda` to the WRITE cycle.
- Maximum bus access rate: one access per 2 cycles.
- `fifo_cnt` updates at the posedge ending READ (+1) or WRITE (−1).

## Test plan
- Reset with `br_cfg`=01, then release → DIVL drives 8'h8B at `ioaddr` 10; next cycle DIVH drives 8'h02 at `ioaddr` 11; then `cfg_done`=1, `iocs`=0.
- Echo mode, `tbr`=1: SPART returns 8'hA7 on `rda` → READ cycle with `iorw`=1, then WRITE cycle drives 8'hA7 at `ioaddr` 00. `fifo_cnt` goes 0→1→0.
- Echo mode, `tbr`=0, five bytes offered with depth 4 → exactly four READs, `fifo_cnt`=4, fifth `rda` left pending. Raise `tbr` → four WRITEs in order, then the fifth byte is read and echoed.
- Change `br_cfg` 00→11 in IDLE → `cfg_done`=0, DIVL drives 8'hA3, DIVH drives 8'h00, then `cfg_done`=1. A queued FIFO byte is still echoed afterwards.
- `ECHO_EN`=0, `tbr`=1, `rda` pulsed with 8'h3C → READ issued, byte discarded; every WRITE drives 8'h55.
- `rst` asserted during a WRITE cycle → next cycle `iocs`=0, `databus` high-Z, `fifo_cnt`=0; divisor sequence restarts after release.
